// File: rtl/axil2apb.sv
// AXI4-Lite slave to APB master bridge: one APB transfer at a time, with
// read/write arbitration that alternates whenever both request types are waiting.
module axil2apb #(
  parameter int C_AXI_ADDR_WIDTH = 12,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter bit OPT_RD_PRIORITY  = 1'b0
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  output logic [1:0]                    S_AXI_BRESP,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          M_APB_PSEL,
  output logic                          M_APB_PENABLE,
  output logic                          M_APB_PWRITE,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_APB_PADDR,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_APB_PWDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] M_APB_PWSTRB,
  output logic [2:0]                    M_APB_PPROT,
  input  logic                          M_APB_PREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   M_APB_PRDATA,
  input  logic                          M_APB_PSLVERR
);

  localparam int SW = C_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state_q, state_d;
  logic   rd_pri_q;     // 1: reads win the next simultaneous request
  logic   wr_req, rd_req;
  logic   grant_wr, grant_rd;
  logic   apb_done;
  logic   resp_done;
  logic   pwrite_q;
  logic [1:0] resp_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_req    = S_AXI_AWVALID && S_AXI_WVALID;
    rd_req    = S_AXI_ARVALID;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    apb_done  = 1'b0;
    resp_done = 1'b0;
    state_d   = state_q;
    case (state_q)
      IDLE: begin
        // Readies are grants; gating with reset keeps them low while reset is held.
        if (S_AXI_ARESETN) begin
          grant_rd = rd_req && (!wr_req || rd_pri_q);
          grant_wr = wr_req && !(rd_req && rd_pri_q);
        end
        if (grant_rd || grant_wr) state_d = SETUP;
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (M_APB_PREADY) begin
          apb_done = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        resp_done = pwrite_q ? S_AXI_BREADY : S_AXI_RREADY;
        if (resp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with <= only, so every register samples pre-edge values.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_pri_q <= OPT_RD_PRIORITY;
      resp_q   <= 2'b00;
    end else begin
      if (grant_rd)      rd_pri_q <= 1'b0;
      else if (grant_wr) rd_pri_q <= 1'b1;
      if (apb_done)      resp_q   <= M_APB_PSLVERR ? 2'b10 : 2'b00;
    end
  end

  // NOTE: pure data registers carry no reset; they are only observed once the
  // control path (state, valids) has qualified them.
  always_ff @(posedge S_AXI_ACLK) begin
    if (grant_rd) begin
      M_APB_PADDR  <= S_AXI_ARADDR;
      M_APB_PPROT  <= S_AXI_ARPROT;
      M_APB_PWSTRB <= '0;
      pwrite_q     <= 1'b0;
    end else if (grant_wr) begin
      M_APB_PADDR  <= S_AXI_AWADDR;
      M_APB_PPROT  <= S_AXI_AWPROT;
      M_APB_PWDATA <= S_AXI_WDATA;
      M_APB_PWSTRB <= S_AXI_WSTRB[SW-1:0];
      pwrite_q     <= 1'b1;
    end
    if (apb_done && !pwrite_q) S_AXI_RDATA <= M_APB_PRDATA;
  end

  assign S_AXI_AWREADY = grant_wr;
  assign S_AXI_WREADY  = grant_wr;
  assign S_AXI_ARREADY = grant_rd;
  assign M_APB_PSEL    = (state_q == SETUP) || (state_q == ACCESS);
  assign M_APB_PENABLE = (state_q == ACCESS);
  assign M_APB_PWRITE  = pwrite_q;
  assign S_AXI_BVALID  = (state_q == RESP) && pwrite_q;
  assign S_AXI_RVALID  = (state_q == RESP) && !pwrite_q;
  assign S_AXI_BRESP   = resp_q;
  assign S_AXI_RRESP   = resp_q;

endmodule

// File: tb/tb_axil2apb.sv
// Self-checking bench for axil2apb: directed scenarios plus randomized transfers
// checked against a transaction-level model of the bridge.
module tb_axil2apb;

  localparam int AW     = 12;
  localparam int DW     = 32;
  localparam int SW     = DW / 8;
  localparam bit OPT_RD = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          awvalid = 0, wvalid = 0, arvalid = 0, bready = 0, rready = 0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [2:0]    awprot = '0, arprot = '0;
  logic [DW-1:0] wdata = '0, prdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          pready = 0, pslverr = 0;
  logic          awready, wready, arready, bvalid, rvalid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata, pwdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [SW-1:0] pwstrb;
  logic [2:0]    pprot;

  int            n_chk = 0;
  int            n_bad = 0;
  logic [DW-1:0] last_wdata = '0;

  always #5 clk = ~clk;

  axil2apb #(.C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW), .OPT_RD_PRIORITY(OPT_RD)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .M_APB_PSEL(psel), .M_APB_PENABLE(penable), .M_APB_PWRITE(pwrite), .M_APB_PADDR(paddr),
    .M_APB_PWDATA(pwdata), .M_APB_PWSTRB(pwstrb), .M_APB_PPROT(pprot),
    .M_APB_PREADY(pready), .M_APB_PRDATA(prdata), .M_APB_PSLVERR(pslverr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_apb(input string tag, input bit e_sel, input bit e_en, input logic [AW-1:0] e_addr,
                           input bit e_wr, input logic [2:0] e_prot, input logic [DW-1:0] e_data,
                           input logic [SW-1:0] e_strb);
    check({tag, ".psel"},    psel,    e_sel);
    check({tag, ".penable"}, penable, e_en);
    check({tag, ".paddr"},   paddr,   e_addr);
    check({tag, ".pwrite"},  pwrite,  e_wr);
    check({tag, ".pprot"},   pprot,   e_prot);
    check({tag, ".pwdata"},  pwdata,  e_data);
    check({tag, ".pwstrb"},  pwstrb,  e_strb);
  endtask

  // One complete AXI transfer with a scripted APB slave. wlag delays WVALID behind
  // AWVALID; waits is the number of PREADY-low ACCESS cycles; bdly holds xREADY low.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [SW-1:0] strb, input logic [2:0] prot, input logic [DW-1:0] rdat,
                         input int waits, input bit err, input int bdly, input int wlag);
    logic [DW-1:0] e_data;
    logic [SW-1:0] e_strb;
    logic [1:0]    e_resp;
    int            n;
    @(negedge clk);
    if (wr) begin
      awaddr = addr; awprot = prot; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = (wlag == 0);
    end else begin
      araddr = addr; arprot = prot; arvalid = 1'b1;
    end
    #1;
    for (int i = 0; i < wlag; i++) begin
      check("lone_aw.awready", awready, 1'b0);
      check("lone_aw.psel", psel, 1'b0);
      @(negedge clk); #1;
    end
    if (wr) wvalid = 1'b1;
    #1;
    n = 0;
    while (!(wr ? awready : arready) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("accept.ready", wr ? awready : arready, 1'b1);
    if (wr) check("accept.wready", wready, 1'b1);
    check("accept.other_ready", wr ? arready : awready, 1'b0);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    e_data = wr ? data : last_wdata;
    e_strb = wr ? strb : '0;
    if (wr) last_wdata = data;
    check_apb("setup", 1, 0, addr, wr, prot, e_data, e_strb);
    @(posedge clk); #1;
    check_apb("access", 1, 1, addr, wr, prot, e_data, e_strb);
    for (int i = 0; i < waits; i++) begin
      pready = 0; prdata = $urandom; pslverr = 1'($urandom);
      @(posedge clk); #1;
      check_apb("wait", 1, 1, addr, wr, prot, e_data, e_strb);
      check("wait.xvalid", bvalid | rvalid, 1'b0);
    end
    pready = 1; prdata = rdat; pslverr = err;
    @(posedge clk); #1;
    pready = 0; prdata = $urandom; pslverr = 1'($urandom);
    e_resp = err ? 2'b10 : 2'b00;
    for (int i = 0; i <= bdly; i++) begin
      if (i > 0) begin
        arvalid = 1'b1;
        @(posedge clk); #1;
        check("resp.arready_blocked", arready, 1'b0);
      end
      check("resp.psel", psel, 1'b0);
      check("resp.penable", penable, 1'b0);
      check("resp.bvalid", bvalid, wr);
      check("resp.rvalid", rvalid, !wr);
      if (wr) check("resp.bresp", bresp, e_resp);
      else begin
        check("resp.rresp", rresp, e_resp);
        check("resp.rdata", rdata, rdat);
      end
    end
    arvalid = 0;
    bready = wr; rready = !wr;
    @(posedge clk); #1;
    bready = 0; rready = 0;
    check("handshake.valid_low", bvalid | rvalid, 1'b0);
  endtask

  // Both request types held every cycle: grants must alternate, starting with the
  // reset-time priority, one every 4 cycles. Caller enters at a negedge.
  task automatic arb_test();
    bit order[$];
    int when[$];
    int both = 0;
    int cyc = 0;
    pready = 1; pslverr = 0; bready = 1; rready = 1;
    awaddr = 12'h0A4; awprot = 3'b001; wdata = 32'hA5A5_5A5A; wstrb = '1;
    araddr = 12'h0B8; arprot = 3'b010;
    awvalid = 1; wvalid = 1; arvalid = 1;
    while (order.size() < 6 && cyc < 100) begin
      #1;
      if (awready && arready) both++;
      if (awready) begin order.push_back(1'b0); when.push_back(cyc); end
      else if (arready) begin order.push_back(1'b1); when.push_back(cyc); end
      @(negedge clk);
      cyc++;
    end
    awvalid = 0; wvalid = 0; arvalid = 0;
    repeat (4) @(posedge clk);
    #1;
    pready = 0; bready = 0; rready = 0;
    last_wdata = 32'hA5A5_5A5A;
    check("arb.count", order.size(), 6);
    check("arb.both_ready", both, 0);
    if (order.size() > 0) check("arb.first_cycle", when[0], 0);
    for (int i = 0; i < order.size(); i++) begin
      check("arb.order", order[i], OPT_RD ^ i[0]);
      if (i > 0) check("arb.gap", when[i] - when[i-1], 4);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with every request asserted: nothing may respond.
    awvalid = 1; wvalid = 1; arvalid = 1;
    #3;
    check("rst.awready", awready, 0);
    check("rst.wready", wready, 0);
    check("rst.arready", arready, 0);
    check("rst.bvalid", bvalid, 0);
    check("rst.rvalid", rvalid, 0);
    check("rst.psel", psel, 0);
    check("rst.penable", penable, 0);
    check("rst.bresp", bresp, 0);
    check("rst.rresp", rresp, 0);
    @(posedge clk); #1;
    check("rst.psel_after_edge", psel, 0);
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    rst_n = 1;
    arb_test();

    // Directed scenarios.
    run_txn(1, 12'h010, 32'hDEAD_BEEF, 4'hF, 3'b000, '0, 0, 0, 0, 0);
    run_txn(0, 12'h020, '0, '0, 3'b000, 32'h1234_5678, 3, 0, 0, 0);
    run_txn(1, 12'h030, 32'hCAFE_0001, 4'h5, 3'b011, '0, 1, 1, 0, 0);
    run_txn(0, 12'h034, '0, '0, 3'b100, 32'h0BAD_0BAD, 1, 0, 0, 0);
    run_txn(1, 12'h040, 32'h0000_FFFF, 4'h3, 3'b000, '0, 0, 0, 0, 4);
    run_txn(0, 12'h044, '0, '0, 3'b000, 32'h8765_4321, 0, 0, 5, 0);
    run_txn(0, 12'hFFF, '0, '0, 3'b111, 32'hFFFF_FFFF, 0, 1, 0, 0);

    // Randomized transfers.
    for (int t = 0; t < 40; t++) begin
      bit w;
      w = 1'($urandom);
      run_txn(w, AW'($urandom), $urandom, SW'($urandom), 3'($urandom), $urandom,
              int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 2)),
              w ? int'($urandom_range(0, 2)) : 0);
    end

    // Reset in the middle of a write's ACCESS phase.
    @(negedge clk);
    awaddr = 12'h3C0; wdata = 32'h0BAD_F00D; wstrb = 4'h3; awprot = 3'b000;
    awvalid = 1; wvalid = 1; pready = 0;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    last_wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    check("abort.in_access", penable, 1);
    #2;
    rst_n = 0;
    awvalid = 1; wvalid = 1; arvalid = 1;
    #1;
    check("abort.psel", psel, 0);
    check("abort.penable", penable, 0);
    check("abort.bvalid", bvalid, 0);
    check("abort.rvalid", rvalid, 0);
    check("abort.awready", awready, 0);
    check("abort.arready", arready, 0);
    repeat (2) @(posedge clk);
    #1;
    check("abort.no_resp", bvalid | rvalid | psel, 0);
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    rst_n = 1;
    arb_test();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/axil2apb.md
AXIL2APB -- requirements
Module: axil2apb

Interface
REQ-001 SHALL have parameter C_AXI_ADDR_WIDTH, default 12, giving the AXI-lite and APB address width (AW).
REQ-002 SHALL have parameter C_AXI_DATA_WIDTH, default 32, giving the data width (DW); legal values are 32 and 64 only.
REQ-003 SHALL have parameter OPT_RD_PRIORITY, default 0, giving the grant to reads (1) or writes (0) on the first simultaneous request after reset.
REQ-004 SHALL have the port S_AXI_ACLK, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 SHALL have the port S_AXI_ARESETN, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have the port S_AXI_AWVALID/AWREADY, in/out, 1 bit each: write-address handshake.
REQ-007 SHALL have the port S_AXI_AWADDR, in, AW bits, and S_AXI_AWPROT, in, 3 bits: write address and protection.
REQ-008 SHALL have the port S_AXI_WVALID/WREADY, in/out, 1 bit each: write-data handshake.
REQ-009 SHALL have the port S_AXI_WDATA, in, DW bits, and S_AXI_WSTRB, in, DW/8 bits: write data and byte strobes.
REQ-010 SHALL have the port S_AXI_BVALID/BREADY, out/in, 1 bit each, and S_AXI_BRESP, out, 2 bits: write response.
REQ-011 SHALL have the port S_AXI_ARVALID/ARREADY, in/out, 1 bit each: read-address handshake.
REQ-012 SHALL have the port S_AXI_ARADDR, in, AW bits, and S_AXI_ARPROT, in, 3 bits: read address and protection.
REQ-013 SHALL have the port S_AXI_RVALID/RREADY, out/in, 1 bit each; S_AXI_RDATA, out, DW bits; and S_AXI_RRESP, out, 2 bits: read response.
REQ-014 SHALL have the ports M_APB_PSEL, M_APB_PENABLE, M_APB_PWRITE, all out, 1 bit each: APB control.
REQ-015 SHALL have the ports M_APB_PADDR, out, AW bits; M_APB_PWDATA, out, DW bits; M_APB_PWSTRB, out, DW/8 bits; and M_APB_PPROT, out, 3 bits.
REQ-016 SHALL have the ports M_APB_PREADY, in, 1 bit; M_APB_PRDATA, in, DW bits; and M_APB_PSLVERR, in, 1 bit.

Function
REQ-017 SHALL implement the states IDLE, SETUP, ACCESS and RESP, and only these.
REQ-018 SHALL assert AWREADY and WREADY together, in the same cycle, and only in IDLE; a write request SHALL mean AWVALID and WVALID both high.
REQ-019 SHALL assert ARREADY only in IDLE, and never in the same cycle as AWREADY.
REQ-020 SHALL, in IDLE when both a read and a write request are present, grant the type not granted last; after reset, OPT_RD_PRIORITY decides.
REQ-021 SHALL, on a grant, register the address, PROT, WRITE, WDATA and WSTRB onto the M_APB_* outputs, move to SETUP, and drive PSEL=1, PENABLE=0 in the next cycle.
REQ-022 SHALL move from SETUP to ACCESS unconditionally, with PSEL=1 and PENABLE=1 in ACCESS.
REQ-023 SHALL, in ACCESS with PREADY=0, hold all M_APB_* outputs stable; there is no timeout.
REQ-024 SHALL, in ACCESS with PREADY=1, drop PSEL and PENABLE the next cycle, enter RESP, and raise BVALID (write) or RVALID (read).
REQ-025 SHALL drive xRESP=2'b10 (SLVERR) when PSLVERR=1 at completion, and 2'b00 otherwise; PSLVERR is ignored unless PSEL, PENABLE and PREADY are all high.
REQ-026 SHALL capture RDATA from PRDATA at read completion; on a write response RDATA is don't-care; RDATA, RRESP and BRESP SHALL hold while xVALID is high.
REQ-027 SHALL hold BVALID/RVALID until BREADY/RREADY, then return to IDLE; the next grant is possible in that same IDLE cycle.
REQ-028 SHALL give a minimum of 4 cycles per transfer (accept, SETUP, ACCESS, RESP) and never more than one APB transfer outstanding.
REQ-029 SHALL drive PWSTRB=0 for reads; PWDATA SHALL keep its last value for reads.
REQ-030 SHALL pass addresses unmodified, with no alignment or decode.

Reset
REQ-031 SHALL, while S_AXI_ARESETN=0, asynchronously drive to 0: AWREADY, WREADY, ARREADY, BVALID, RVALID, PSEL, PENABLE, BRESP and RRESP; the state returns to IDLE and the grant-history bit returns to its OPT_RD_PRIORITY value.
REQ-032 SHALL, on reset in the middle of a transfer, abandon it with no response issued; data registers need not be reset.
REQ-033 SHALL leave the first IDLE cycle after reset deassertion able to accept a request.

Verification
REQ-034 SHALL cover a write: AWADDR=0x010, WDATA=0xDEADBEEF, WSTRB=0xF, PREADY=1 -> PSEL 1 cycle later, PENABLE 2 later, BVALID 3 later, BRESP=00.
REQ-035 SHALL cover a read with wait states: ARADDR=0x020, PREADY low 3 ACCESS cycles, PRDATA=0x12345678 -> RVALID with RDATA=0x12345678 and RRESP=00; APB outputs stable throughout.
REQ-036 SHALL cover an error: a write with PSLVERR=1 at completion -> BRESP=10; the following read with PSLVERR=0 -> RRESP=00.
REQ-037 SHALL cover simultaneous AW+W and AR every cycle for 6 transfers -> strict alternation starting per OPT_RD_PRIORITY; never ARREADY and AWREADY in the same cycle.
REQ-038 SHALL cover backpressure and reset: RREADY held low 5 cycles -> RVALID/RDATA stable and no new APB transfer; reset asserted in ACCESS -> PSEL, PENABLE and all xVALID at 0 immediately.
REQ-039 SHALL cover a lone AWVALID with WVALID=0 for 4 cycles -> no AWREADY and no PSEL until WVALID rises.
